// File: rtl/vga_scan_ctrl.sv
// VGA scan timing generator: pixel divider, h/v counters, latency-aligned sync/blank
// and a registered RGB332 output stage that blacks out everything outside the visible area.
module vga_scan_ctrl #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int CLK_DIV     = 2,
  parameter int PIPE        = 1,
  parameter int SYNC_ACTIVE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       blank_req,
  input  logic [2:0] pix_red,
  input  logic [2:0] pix_green,
  input  logic [1:0] pix_blue,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_tick,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic       SYNC_ON  = (SYNC_ACTIVE != 0);

  logic [DW-1:0] div;
  logic [9:0]    h;
  logic [9:0]    v;
  logic          vis;
  logic          hs_raw;
  logic          vs_raw;
  logic [2:0]    raw;
  logic [2:0]    dly;

  // With CLK_DIV = 1 the divider never leaves 0, so the tick is held high.
  assign pix_tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (pix_tick) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign x = h;
  assign y = v;
  assign frame_start = pix_tick && (h == H_LAST) && (v == V_LAST);

  assign vis    = (h < H_VIS) && (v < V_VIS);
  assign hs_raw = (h >= HS_START) && (h < HS_END);
  assign vs_raw = (v >= VS_START) && (v < VS_END);
  assign raw    = {vis, hs_raw, vs_raw};

  // Flags are delayed to match the renderer latency so they line up with pix_*.
  generate
    if (PIPE == 0) begin : g_nopipe
      assign dly = raw;
    end else begin : g_pipe
      logic [PIPE-1:0][2:0] sr;
      always_ff @(posedge clk) begin
        if (reset) begin
          sr <= '0;
        end else if (pix_tick) begin
          sr[0] <= raw;
          for (int i = 1; i < PIPE; i++) begin
            sr[i] <= sr[i-1];
          end
        end
      end
      assign dly = sr[PIPE-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync    <= ~SYNC_ON;
      vsync    <= ~SYNC_ON;
      video_on <= 1'b0;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
    end else if (pix_tick) begin
      hsync    <= dly[1] ? SYNC_ON : ~SYNC_ON;
      vsync    <= dly[0] ? SYNC_ON : ~SYNC_ON;
      video_on <= dly[2];
      if (dly[2] && !blank_req) begin
        red   <= pix_red;
        green <= pix_green;
        blue  <= pix_blue;
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Sequences the pixel datapath: generates 640x480@60 scan timing and drives the x/y coordinates consumed by the border and tile renderers.
- Latency-aligns hsync, vsync and blanking to the renderer's pipeline depth.
- Registers the renderer's RGB332 colour onto the VGA pins and forces black outside the visible area.
- Sits between the system clock and the VGA connector; the renderers are purely downstream of its x/y.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (legal 1..4)
- PIPE, 1, renderer latency in pixel ticks (legal 0..4)
- SYNC_ACTIVE, 0, sync pulse polarity (0 = active-low)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- blank_req  input  1  force black output (e.g. during board update); sampled on pixel tick
- pix_red  input  3  renderer red for the coordinate issued PIPE ticks earlier
- pix_green  input  3  renderer green
- pix_blue  input  2  renderer blue
- x  output  10  current horizontal count, 0..H_TOTAL-1
- y  output  10  current vertical count, 0..V_TOTAL-1
- pix_tick  output  1  one-clk strobe, pixel advance
- frame_start  output  1  one-clk pulse when the counters enter (0,0)
- hsync  output  1  aligned horizontal sync
- vsync  output  1  aligned vertical sync
- video_on  output  1  aligned visible-area flag
- red  output  3  registered red to DAC
- green  output  3  registered green to DAC
- blue  output  2  registered blue to DAC

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Both fit in 10 bits.
- Divider: counts 0..CLK_DIV-1. pix_tick = 1 in the clk where the divider equals CLK_DIV-1. When CLK_DIV = 1, pix_tick is constant 1 after reset.
- Horizontal counter: on pix_tick, h = (h == H_TOTAL-1) ? 0 : h+1.
- Vertical counter: v advances only on a tick where h wraps. v = (v == V_TOTAL-1) ? 0 : v+1.
- x = h and y = v, driven directly from the counter registers. There is no extra latency.
- Raw flags, combinational from h/v:
  - vis = (h < H_VISIBLE) && (v < V_VISIBLE)
  - hs_raw active when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751)
  - vs_raw active when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491)
- Delay line: {vis, hs_raw, vs_raw} pass through a PIPE-stage shift register that advances only on pix_tick. PIPE = 0 means pass-through.
- Output stage, one further register updated on pix_tick:
  - hsync and vsync are driven at the SYNC_ACTIVE level when their delayed flag is set.
  - video_on takes the delayed vis.
  - red/green/blue load pix_* when (delayed vis && !blank_req); otherwise they load 0.
- Total latency from x/y change to colour/sync on the pins: PIPE+1 pixel ticks. Sync and colour are always mutually aligned.
- frame_start = 1 for exactly one clk: the clk in which pix_tick=1, h=H_TOTAL-1 and v=V_TOTAL-1.
- Reset (synchronous, dominates everything, may be asserted mid-line or mid-frame):
  - divider, h, v and all delay stages go to 0 / inactive.
  - red/green/blue = 0, video_on = 0, frame_start = 0.
  - hsync and vsync go to the inactive level (1 when SYNC_ACTIVE=0).
  - x = y = 0.
  - The first pix_tick occurs CLK_DIV clks after reset deasserts.
- blank_req only masks colour. Timing, sync and x/y are unaffected.
- Outputs hold their values between ticks. No output changes except on a pix_tick clk, and frame_start is the only one-clk pulse.

Test Plan:
- Reset release, CLK_DIV=2, PIPE=1 -> pix_tick toggles every 2nd clk; x steps 0,1,2,...; red/green/blue = 0 and hsync = vsync = 1 until the first visible pixel emerges 2 ticks later.
- Run one full line -> x wraps 799->0 and y increments 0->1 on the same tick; hsync is low for exactly 96 ticks, starting 2 ticks after x = 656.
- Run one full frame -> vsync is low for 2 lines beginning when y = 490 (plus 2-tick offset); frame_start pulses once per 525x800 ticks, in the clk of the 799/524 -> 0/0 wrap.
- Drive pix = 3'b111/3'b111/2'b11 constantly -> output is white only while video_on = 1; it is 0 for x >= 640 or y >= 480 (aligned); assert blank_req mid-line -> black from the next tick, sync unchanged.
- PIPE=0 vs PIPE=3 -> colour of pixel x = 100 appears at the pins 1 and 4 ticks after x = 100 respectively, with hsync shifted identically.
- Assert reset at x = 400, y = 200 for 1 clk -> next clk x = y = 0, all colour 0, syncs inactive; the timing sequence restarts cleanly with the first tick CLK_DIV clks later.
